// File: rtl/sync_fifo_pkg.sv
// ============================================================================
//  Module      : sync_fifo_pkg
//  Description : Shared types and elaboration-time helpers for the
//                parametrised synchronous FIFO: pointer/count width helpers,
//                the packed status struct, the status decoder and the
//                parameter legality check.
//  Macros      : none here (SYNC_FIFO_ERR_EN is consumed by sync_fifo_param)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_status_t;

   // Pointer width; a single-entry array would still need one address bit.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Occupancy width: one extra bit so that DEPTH itself is representable.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   function automatic bit params_legal(input int data_w, input int depth,
                                       input int af_level, input int ae_level);
      return (data_w >= 1) && (depth >= 4) && is_pow2(depth) &&
             (ae_level < af_level) && (af_level <= depth);
   endfunction

   // All flags are pure decodes of the registered occupancy.
   function automatic fifo_status_t decode_status(input int cnt, input int depth,
                                                  input int af_level, input int ae_level);
      fifo_status_t s;
      s.full         = (cnt == depth);
      s.empty        = (cnt == 0);
      s.almost_full  = (cnt >= af_level);
      s.almost_empty = (cnt <= ae_level);
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_param_if.sv
// ============================================================================
//  Module      : sync_fifo_param_if
//  Description : Producer/consumer bus of the synchronous FIFO.
//                master : drives wr, din, rd, err_clr; observes the rest
//                slave  : the FIFO itself
//  Ports       : wr, din, rd, err_clr, dout, full, empty, almost_full,
//                almost_empty, fifo_cnt, overflow, underflow
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sync_fifo_param_if
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   localparam int CNT_W = cnt_w(DEPTH);

   logic              wr;
   logic [DATA_W-1:0] din;
   logic              rd;
   logic              err_clr;
   logic [DATA_W-1:0] dout;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [CNT_W-1:0]  fifo_cnt;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr, din, rd, err_clr,
      input  dout, full, empty, almost_full, almost_empty, fifo_cnt,
             overflow, underflow
   );

   modport slave (
      input  wr, din, rd, err_clr,
      output dout, full, empty, almost_full, almost_empty, fifo_cnt,
             overflow, underflow
   );

endinterface

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// ============================================================================
//  Module      : sync_fifo_mem
//  Description : Simple dual-port storage array: one write port, one read
//                port with a registered output. The output register resets to
//                zero and holds its value when no read is requested. The
//                array itself is not reset.
//  Ports       : clk, rst, i_we, i_waddr, i_wdata, i_re, i_raddr, o_rdata
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = ptr_w(DEPTH)
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              i_we,
   input  wire logic [ADDR_W-1:0] i_waddr,
   input  wire logic [DATA_W-1:0] i_wdata,
   input  wire logic              i_re,
   input  wire logic [ADDR_W-1:0] i_raddr,
   output logic      [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   always_ff @(posedge clk) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
   end

   // Read samples the array before this edge's write lands, so a read and a
   // write to the same slot (full FIFO) return the old word.
   always_comb begin
      rdata_d = rdata_q;
      if (i_re) begin
         rdata_d = mem_q[i_raddr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign o_rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ============================================================================
//  Module      : sync_fifo_param
//  Description : Parametrised single-clock FIFO with programmable
//                almost-full/almost-empty thresholds and optional sticky
//                overflow/underflow flags.
//  Ports       : clk  - sole clock (posedge)
//                rst  - synchronous active-high reset
//                bus  - sync_fifo_param_if.slave (wr, din, rd, err_clr in;
//                       dout, full, empty, almost_full, almost_empty,
//                       fifo_cnt, overflow, underflow out)
//  Macros      : SYNC_FIFO_ERR_EN - enables the sticky overflow/underflow
//                flags; when undefined both read 0 and err_clr is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input wire logic          clk,
   input wire logic          rst,
   sync_fifo_param_if.slave  bus
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);

   generate
      if (!params_legal(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_chk
         $error("sync_fifo_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL");
      end
   endgenerate

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic [DATA_W-1:0] dout;
   fifo_status_t      status;
   logic              wr_acc;
   logic              rd_acc;

   always_comb begin
      status = decode_status(int'(cnt_q), DEPTH, AF_LEVEL, AE_LEVEL);
   end

   // A read is only refused when empty. A write is refused when full unless
   // a read frees a slot on the same edge, which keeps full-rate streaming
   // at DEPTH occupancy. No bypass when empty: the read is simply dropped.
   always_comb begin
      rd_acc = bus.rd && !status.empty;
      wr_acc = bus.wr && (!status.full || rd_acc);
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({wr_acc, rd_acc})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   sync_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .i_we    (wr_acc),
      .i_waddr (wr_ptr_q),
      .i_wdata (bus.din),
      .i_re    (rd_acc),
      .i_raddr (rd_ptr_q),
      .o_rdata (dout)
   );

`ifdef SYNC_FIFO_ERR_EN
   logic overflow_q,  overflow_d;
   logic underflow_q, underflow_d;

   // Error attempts are judged on the raw request against the registered
   // flags; a fresh error outranks a clear on the same edge.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (bus.err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (bus.wr && status.full) begin
         overflow_d = 1'b1;
      end
      if (bus.rd && status.empty) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = bus.err_clr;
   assign bus.overflow   = 1'b0;
   assign bus.underflow  = 1'b0;
`endif

   assign bus.dout         = dout;
   assign bus.fifo_cnt     = cnt_q;
   assign bus.full         = status.full;
   assign bus.empty        = status.empty;
   assign bus.almost_full  = status.almost_full;
   assign bus.almost_empty = status.almost_empty;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
//  Module      : tb_sync_fifo_param
//  Description : Directed scoreboard bench for sync_fifo_param (DEPTH=16,
//                DATA_W=8, AF_LEVEL=14, AE_LEVEL=2). Each stimulus cycle
//                pushes the expected post-edge outputs; a monitor pops and
//                compares them on the following falling edge.
//  Macros      : SYNC_FIFO_ERR_EN - sticky error flag expectations
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_param;

   localparam int DW = 8;
   localparam int DP = 16;

   typedef struct {
      logic [DW-1:0] dout;
      int            cnt;
      bit            full;
      bit            empty;
      bit            af;
      bit            ae;
      bit            ovf;
      bit            udf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

   sync_fifo_param #(
      .DATA_W   (DW),
      .DEPTH    (DP),
      .AF_LEVEL (DP - 2),
      .AE_LEVEL (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   exp_t          exp_q[$];
   logic [DW-1:0] m_data[$];
   logic [DW-1:0] m_dout = '0;
   bit            m_ovf  = 1'b0;
   bit            m_udf  = 1'b0;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // One clock of stimulus; expected state follows the FIFO's documented
   // acceptance rules and is queued once the edge has happened.
   task automatic step(input bit w, input logic [DW-1:0] d, input bit r,
                       input bit clr, input bit rs);
      exp_t e;
      bit   m_full, m_empty, racc, wacc;
      int   n;
      rst         = rs;
      bus.wr      = w;
      bus.din     = d;
      bus.rd      = r;
      bus.err_clr = clr;
      if (rs) begin
         m_data.delete();
         m_dout = '0;
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
      end else begin
         m_full  = (m_data.size() == DP);
         m_empty = (m_data.size() == 0);
         racc    = r && !m_empty;
         wacc    = w && (!m_full || racc);
`ifdef SYNC_FIFO_ERR_EN
         if (clr) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
         end
         if (w && m_full)  m_ovf = 1'b1;
         if (r && m_empty) m_udf = 1'b1;
`endif
         if (racc) m_dout = m_data.pop_front();
         if (wacc) m_data.push_back(d);
      end
      n      = m_data.size();
      e.dout = m_dout;
      e.cnt  = n;
      e.full = (n == DP);
      e.empty = (n == 0);
      e.af   = (n >= DP - 2);
      e.ae   = (n <= 2);
      e.ovf  = m_ovf;
      e.udf  = m_udf;
      @(posedge clk);
      #1;
      exp_q.push_back(e);
   endtask

   // Monitor: the DUT presents a fresh output state after every edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("dout",         int'(bus.dout),         int'(e.dout));
         chk("fifo_cnt",     int'(bus.fifo_cnt),     e.cnt);
         chk("full",         int'(bus.full),         int'(e.full));
         chk("empty",        int'(bus.empty),        int'(e.empty));
         chk("almost_full",  int'(bus.almost_full),  int'(e.af));
         chk("almost_empty", int'(bus.almost_empty), int'(e.ae));
         chk("overflow",     int'(bus.overflow),     int'(e.ovf));
         chk("underflow",    int'(bus.underflow),    int'(e.udf));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.wr      = 1'b0;
      bus.din     = '0;
      bus.rd      = 1'b0;
      bus.err_clr = 1'b0;

      // Reset then idle
      step(0, 8'h00, 0, 0, 1);
      step(0, 8'h00, 0, 0, 1);
      repeat (2) step(0, 8'h00, 0, 0, 0);

      // Fill with 0x01..0x10
      for (int i = 1; i <= DP; i++) step(1, 8'(i), 0, 0, 0);

      // 17th write while full is dropped; overflow sticks until cleared
      step(1, 8'hAA, 0, 0, 0);
      step(0, 8'h00, 0, 0, 0);
      step(0, 8'h00, 0, 1, 0);
      step(0, 8'h00, 0, 0, 0);

      // Simultaneous write/read while full: count stays, oldest word out
      step(1, 8'h77, 1, 0, 0);
      step(0, 8'h00, 0, 1, 0);

      // Drain: 0x02..0x10 then 0x77
      for (int i = 0; i < DP; i++) step(0, 8'h00, 1, 0, 0);

      // Read while empty, then clear and error coincident (set wins)
      step(0, 8'h00, 1, 0, 0);
      step(0, 8'h00, 1, 1, 0);
      step(0, 8'h00, 0, 1, 0);

      // Simultaneous write/read while empty: no bypass
      step(1, 8'h55, 1, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      step(0, 8'h00, 0, 1, 0);

      // Wrap-around streaming at occupancy 3
      for (int i = 0; i < 3; i++) step(1, 8'(8'h80 + i), 0, 0, 0);
      for (int i = 0; i < 40; i++) step(1, 8'(8'hA0 + i), 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);

      // Reset with 9 entries queued, then one write/read
      for (int i = 0; i < 9; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
      step(0, 8'h00, 0, 0, 1);
      step(1, 8'h3C, 0, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      step(0, 8'h00, 0, 0, 0);

      repeat (3) @(negedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
